// File: rtl/i2c_target_byte_engine.sv
// I2C target byte engine: START/STOP detection, 7-bit address match, ACK
// generation, write-byte reception and read-byte transmission without clock stretching.
module i2c_target_byte_engine #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       addr_hit,
  output logic       rd_nack,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX_BYTE,
    ST_RX_ACK, ST_TX_BYTE, ST_TX_ACK, ST_WAIT_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   scl_q, sda_q;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rw_q, rw_d;
  logic                phase_q, phase_d;
  logic                sda_drv_q, sda_drv_d;
  logic                busy_q, busy_d;
  logic                rx_valid_q, rx_valid_d;
  logic                tx_req_q, tx_req_d;
  logic                addr_hit_q, addr_hit_d;
  logic                rd_nack_q, rd_nack_d;

  logic                scl_s, sda_s;
  logic                scl_rise, scl_fall, start_det, stop_det;
  logic [BYTE_W-1:0]   sh_in;

  // Open-drain pad: only ever pull low.
  assign I2C_SDA = sda_drv_q ? 1'b0 : 1'bz;

  // Two synchronising flops plus one delay flop per pin; reset to idle-bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[SYNC_W-2:0], I2C_SCL};
      sda_q <= {sda_q[SYNC_W-2:0], I2C_SDA};
    end
  end

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_s & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_s & sda_q[1] & ~sda_q[2];
  assign sh_in     = {shift_q[BYTE_W-2:0], sda_s};

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      sda_drv_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      rd_nack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sda_drv_q  <= sda_drv_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      addr_hit_q <= addr_hit_d;
      rd_nack_q  <= rd_nack_d;
    end
  end

  // Next-state logic; phase_q marks "ACK being driven" or "master ACKed" in the ACK states.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    sda_drv_d  = sda_drv_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    addr_hit_d = 1'b0;
    rd_nack_d  = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bitcnt_d  = '0;
      phase_d   = 1'b0;
      sda_drv_d = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bitcnt_d  = '0;
      phase_d   = 1'b0;
      sda_drv_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: sda_drv_d = 1'b0;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d = sh_in;
            if (bitcnt_q == CNT_W'(7)) begin
              bitcnt_d = '0;
              if (sh_in[7:1] == DEV_ADDR) begin
                addr_hit_d = 1'b1;
                rw_d       = sh_in[0];
                phase_d    = 1'b0;
                state_d    = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else begin
              bitcnt_d = CNT_W'(bitcnt_q + 1'b1);
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_drv_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              phase_d  = 1'b0;
              bitcnt_d = '0;
              if (rw_q) begin
                tx_req_d  = 1'b1;
                shift_d   = tx_data;
                sda_drv_d = ~tx_data[7];
                state_d   = ST_TX_BYTE;
              end else begin
                sda_drv_d = 1'b0;
                state_d   = ST_RX_BYTE;
              end
            end
          end
        end
        ST_RX_BYTE: begin
          if (scl_rise) begin
            shift_d = sh_in;
            if (bitcnt_q == CNT_W'(7)) begin
              rx_data_d  = sh_in;
              rx_valid_d = 1'b1;
              bitcnt_d   = '0;
              phase_d    = 1'b0;
              state_d    = ST_RX_ACK;
            end else begin
              bitcnt_d = CNT_W'(bitcnt_q + 1'b1);
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_drv_d = 1'b1;
              phase_d   = 1'b1;
            end else begin
              sda_drv_d = 1'b0;
              phase_d   = 1'b0;
              state_d   = ST_RX_BYTE;
            end
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (bitcnt_q == CNT_W'(7)) begin
              sda_drv_d = 1'b0;
              bitcnt_d  = '0;
              phase_d   = 1'b0;
              state_d   = ST_TX_ACK;
            end else begin
              bitcnt_d  = CNT_W'(bitcnt_q + 1'b1);
              shift_d   = {shift_q[BYTE_W-2:0], 1'b0};
              sda_drv_d = ~shift_q[BYTE_W-2];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_s) begin
              phase_d = 1'b1;
            end else begin
              rd_nack_d = 1'b1;
              state_d   = ST_WAIT_STOP;
            end
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            bitcnt_d  = '0;
            tx_req_d  = 1'b1;
            shift_d   = tx_data;
            sda_drv_d = ~tx_data[7];
            state_d   = ST_TX_BYTE;
          end
        end
        ST_WAIT_STOP: sda_drv_d = 1'b0;
        default: begin
          state_d   = ST_IDLE;
          sda_drv_d = 1'b0;
        end
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign addr_hit = addr_hit_q;
  assign rd_nack  = rd_nack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_byte_engine.sv
// Bench for i2c_target_byte_engine: bit-banged I2C master with scoreboard queues
// for written bytes and for read bytes handed to the target via tx_data.
module tb_i2c_target_byte_engine;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_w;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, addr_hit, rd_nack, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_hit = 0, cnt_txr = 0, cnt_nack = 0, cnt_rx = 0;
  int exp_hit = 0, exp_txr = 0, exp_nack = 0, exp_rx = 0;
  int tx_cnt  = 0;
  logic [7:0] tx_bytes [4] = '{8'h3C, 8'hC3, 8'h5A, 8'h00};
  logic [7:0] exp_rx_q [$];
  logic [7:0] exp_tx_q [$];

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup (sda_w);
  assign tx_data = tx_bytes[tx_cnt[1:0]];

  always #5 clk = ~clk;

  i2c_target_byte_engine #(.DEV_ADDR(7'h42)) dut (
    .clk(clk), .reset(reset), .I2C_SCL(scl), .I2C_SDA(sda_w),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .addr_hit(addr_hit), .rd_nack(rd_nack), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor and scoreboard pop/push, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (addr_hit) cnt_hit++;
      if (rd_nack)  cnt_nack++;
      if (rx_valid) begin
        cnt_rx++;
        if (exp_rx_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
      end
      if (tx_req) begin
        cnt_txr++;
        exp_tx_q.push_back(tx_bytes[tx_cnt[1:0]]);
        tx_cnt++;
      end
    end
  end

  task automatic bit_cycle(input logic drive_low, output logic sampled);
    #Q m_low = drive_low;
    #Q scl = 1'b1;
    #Q sampled = sda_w;
    #Q scl = 1'b0;
  endtask

  task automatic bus_start();
    m_low = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bus_rstart();
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~b[i], s);
    bit_cycle(1'b0, ack);
  endtask

  task automatic read_byte(input string tag, input logic nack, output logic slot);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) bit_cycle(1'b0, d[i]);
    check({tag, "_txq"}, 32'(exp_tx_q.size()), 32'd1);
    if (exp_tx_q.size() > 0) check({tag, "_byte"}, 32'(d), 32'(exp_tx_q.pop_front()));
    bit_cycle(~nack, slot);
  endtask

  task automatic check_counts(input string tag);
    #(4*Q);
    check({tag, "_hit"},  32'(cnt_hit),  32'(exp_hit));
    check({tag, "_txr"},  32'(cnt_txr),  32'(exp_txr));
    check({tag, "_nack"}, 32'(cnt_nack), 32'(exp_nack));
    check({tag, "_rx"},   32'(cnt_rx),   32'(exp_rx));
    check({tag, "_rxq"},  32'(exp_rx_q.size()), 32'd0);
    check({tag, "_sda"},  32'(sda_w), 32'd1);
  endtask

  initial begin
    #(200_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, slot, s;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_pulses", 32'({rx_valid, tx_req, addr_hit, rd_nack}), 32'd0);
    check("rst_sda", 32'(sda_w), 32'd1);
    #(4*Q);

    // 1: write one byte
    bus_start();
    check("t1_busy", 32'(busy), 32'd1);
    exp_hit++;
    write_byte(8'h84, ack);
    check("t1_addr_ack", 32'(ack), 32'd0);
    exp_rx_q.push_back(8'hA5); exp_rx++;
    write_byte(8'hA5, ack);
    check("t1_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_rxdata", 32'(rx_data), 32'hA5);
    check_counts("t1");

    // 2: address mismatch
    bus_start();
    write_byte(8'h44, ack);
    check("t2_addr_nack", 32'(ack), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    bus_stop();
    check("t2_busy_end", 32'(busy), 32'd0);
    check_counts("t2");

    // 3: read two bytes, ACK then NACK
    bus_start();
    exp_hit++;
    write_byte(8'h85, ack);
    check("t3_addr_ack", 32'(ack), 32'd0);
    exp_txr++;
    read_byte("t3_b0", 1'b0, slot);
    exp_txr++;
    read_byte("t3_b1", 1'b1, slot);
    check("t3_nack_slot", 32'(slot), 32'd1);
    exp_nack++;
    bus_stop();
    check_counts("t3");

    // 4: write then repeated START into a read
    bus_start();
    exp_hit++;
    write_byte(8'h84, ack);
    check("t4_addr_ack", 32'(ack), 32'd0);
    exp_rx_q.push_back(8'h11); exp_rx++;
    write_byte(8'h11, ack);
    check("t4_data_ack", 32'(ack), 32'd0);
    bus_rstart();
    check("t4_busy", 32'(busy), 32'd1);
    exp_hit++;
    write_byte(8'h85, ack);
    check("t4_raddr_ack", 32'(ack), 32'd0);
    exp_txr++;
    read_byte("t4_b0", 1'b1, slot);
    check("t4_nack_slot", 32'(slot), 32'd1);
    exp_nack++;
    bus_stop();
    check("t4_rxdata", 32'(rx_data), 32'h11);
    check_counts("t4");

    // 5: STOP after 4 bits, then a clean transfer
    bus_start();
    exp_hit++;
    write_byte(8'h84, ack);
    bit_cycle(1'b0, s); bit_cycle(1'b1, s); bit_cycle(1'b0, s); bit_cycle(1'b0, s);
    bus_stop();
    check("t5_busy_end", 32'(busy), 32'd0);
    check("t5_rxdata_hold", 32'(rx_data), 32'h11);
    check_counts("t5a");
    bus_start();
    exp_hit++;
    write_byte(8'h84, ack);
    exp_rx_q.push_back(8'h7E); exp_rx++;
    write_byte(8'h7E, ack);
    check("t5_data_ack", 32'(ack), 32'd0);
    bus_stop();
    check_counts("t5b");

    // 6: reset while the address ACK is being driven
    bus_start();
    exp_hit++;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h84;
      bit_cycle(~a[i], s);
    end
    #Q m_low = 1'b0;
    check("t6_ack_driven", 32'(sda_w), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("t6_sda_rel", 32'(sda_w), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rxdata", 32'(rx_data), 32'd0);
    check("t6_pulses", 32'({rx_valid, tx_req, addr_hit, rd_nack}), 32'd0);
    @(negedge clk) reset = 1'b0;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    check("t6_no_start", 32'(busy), 32'd0);
    bus_stop();
    check("t6_busy_end", 32'(busy), 32'd0);
    check_counts("t6a");
    bus_start();
    exp_hit++;
    write_byte(8'h84, ack);
    check("t6_addr_ack", 32'(ack), 32'd0);
    exp_rx_q.push_back(8'h3C); exp_rx++;
    write_byte(8'h3C, ack);
    bus_stop();
    check_counts("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
